// File: rtl/fanout_fork_buffer.sv
// Registered eager-fork stage: a 2-entry token buffer whose head is offered to every
// enabled fanout destination, retired once all of them have accepted it.
module fanout_fork_buffer #(
  parameter int NUM_OUT    = 9,
  parameter int DATA_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [NUM_OUT-1:0]    cfg_mask,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] entry_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [NUM_OUT-1:0]    sent_q, sent_d;

  logic                  push;
  logic                  done;
  logic [NUM_OUT-1:0]    fire;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block infers a latch.
    in_ready  = (count_q != 2'd2);
    push      = in_valid & in_ready;
    out_data  = entry_q[rd_ptr_q];
    out_valid = {NUM_OUT{count_q != 2'd0}} & cfg_mask & ~sent_q;
    fire      = out_valid & out_ready;
    done      = (count_q != 2'd0) & (&(sent_q | fire | ~cfg_mask));
    occupancy = count_q;

    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = done ? ~rd_ptr_q : rd_ptr_q;
    sent_d   = done ? '0 : (sent_q | fire);

    count_d = count_q;
    case ({push, done})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Flush discards this cycle's push and pop along with all held state.
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
      sent_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sent_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      entry_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_fanout_fork_buffer.sv
// Randomised bench for fanout_fork_buffer: a token-queue reference model predicts every
// output each cycle, with directed scenarios for fork, back-pressure, sink and flush/reset.
module tb_fanout_fork_buffer;

  localparam int NUM_OUT    = 9;
  localparam int DATA_WIDTH = 17;
  localparam int LOG_DEPTH  = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  logic [NUM_OUT-1:0]    cfg_mask;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]    out_valid;
  logic [NUM_OUT-1:0]    out_ready;
  logic [1:0]            occupancy;

  fanout_fork_buffer #(.NUM_OUT(NUM_OUT), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .cfg_mask  (cfg_mask),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: held tokens in arrival order, and which destinations took the head.
  logic [DATA_WIDTH-1:0] model_q [$];
  logic [NUM_OUT-1:0]    accepted;
  logic [NUM_OUT-1:0]    mask_edge;

  // Per-destination log of what the DUT actually handed over.
  logic [DATA_WIDTH-1:0] got_data [NUM_OUT][LOG_DEPTH];
  int                    got_n    [NUM_OUT];

  task automatic clear_log();
    for (int i = 0; i < NUM_OUT; i++) got_n[i] = 0;
  endtask

  // One clock cycle: compare DUT against the model at the negedge, then advance the model.
  task automatic step(input string tag);
    logic               exp_ready;
    logic [NUM_OUT-1:0] exp_valid;
    logic               pushed;
    @(negedge clk);
    if (model_q.size() != 0)
      assert (cfg_mask === mask_edge) else $error("cfg_mask changed while tokens held (%s)", tag);

    exp_ready = (model_q.size() < 2);
    exp_valid = (model_q.size() != 0) ? (cfg_mask & ~accepted) : '0;

    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s in_ready: got %0b want %0b", tag, in_ready, exp_ready);
    end
    checks++;
    if (occupancy !== 2'(model_q.size())) begin
      errors++;
      $display("FAIL %s occupancy: got %0d want %0d", tag, occupancy, model_q.size());
    end
    checks++;
    if (out_valid !== exp_valid) begin
      errors++;
      $display("FAIL %s out_valid: got %h want %h", tag, out_valid, exp_valid);
    end
    if (model_q.size() != 0) begin
      checks++;
      if (out_data !== model_q[0]) begin
        errors++;
        $display("FAIL %s out_data: got %h want %h", tag, out_data, model_q[0]);
      end
    end

    if (!reset) begin
      for (int i = 0; i < NUM_OUT; i++)
        if (out_valid[i] === 1'b1 && out_ready[i] && got_n[i] < LOG_DEPTH) begin
          got_data[i][got_n[i]] = out_data;
          got_n[i]++;
        end
    end

    if (reset || flush) begin
      model_q.delete();
      accepted = '0;
    end else begin
      pushed = in_valid && (model_q.size() < 2);
      if (model_q.size() != 0) begin
        accepted |= cfg_mask & out_ready;
        if (&(accepted | ~cfg_mask)) begin
          void'(model_q.pop_front());
          accepted = '0;
        end
      end
      if (pushed) model_q.push_back(in_data);
    end

    @(posedge clk);
    mask_edge = cfg_mask;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; cfg_mask = 9'h1FF;
    in_valid = 1'b0; in_data = '0; out_ready = '0;
    mask_edge = cfg_mask;
    repeat (2) step("reset_held");
    reset = 1'b0;
    repeat (4) step("reset_idle");
    checks++;
    if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_valid !== '0) begin
      errors++;
      $display("FAIL reset_state: got occ=%0d rdy=%0b vld=%h want occ=0 rdy=1 vld=0",
               occupancy, in_ready, out_valid);
    end
  endtask

  task automatic test_stream();
    logic bad;
    clear_log();
    cfg_mask = 9'h1FF; out_ready = '1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = DATA_WIDTH'(k);
      step("stream");
      checks++;
      if (occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_occ: got %0d want 1", occupancy);
      end
    end
    in_valid = 1'b0;
    repeat (2) step("stream_drain");
    for (int i = 0; i < NUM_OUT; i++) begin
      bad = (got_n[i] != 8);
      for (int k = 0; k < 8 && k < got_n[i]; k++)
        if (got_data[i][k] !== DATA_WIDTH'(k + 1)) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL stream_dest%0d: got %0d tokens want 8 in order 1..8", i, got_n[i]);
      end
    end
  endtask

  task automatic test_partial_fork();
    cfg_mask = 9'h005; out_ready = '0;
    in_valid = 1'b1; in_data = 17'h1ABCD;
    step("fork_push");
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 9'h005) begin
      errors++;
      $display("FAIL fork_c1_valid: got %h want 005", out_valid);
    end
    out_ready = 9'h001;
    step("fork_c1");
    out_ready = '0;
    checks++;
    if (out_valid !== 9'h004) begin
      errors++;
      $display("FAIL fork_c2_valid: got %h want 004", out_valid);
    end
    step("fork_c2");
    out_ready = 9'h004;
    checks++;
    if (out_valid !== 9'h004 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL fork_c3: got vld=%h occ=%0d want vld=004 occ=1", out_valid, occupancy);
    end
    step("fork_c3");
    out_ready = '0;
    checks++;
    if (out_valid !== '0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL fork_retire: got vld=%h occ=%0d want vld=0 occ=0", out_valid, occupancy);
    end
    step("fork_idle");
  endtask

  task automatic test_backpressure();
    logic [DATA_WIDTH-1:0] tok [3];
    int idx;
    logic bad;
    clear_log();
    cfg_mask = 9'h1FF; out_ready = '0;
    for (int k = 0; k < 3; k++) tok[k] = DATA_WIDTH'($urandom);
    idx = 0;
    repeat (5) begin
      in_valid = 1'b1; in_data = tok[idx];
      if (model_q.size() < 2) idx++;
      step("bp_fill");
    end
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || idx != 2) begin
      errors++;
      $display("FAIL bp_full: got occ=%0d rdy=%0b held=%0d want occ=2 rdy=0 held=2",
               occupancy, in_ready, idx);
    end
    out_ready = '1;
    step("bp_first_pop");
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_return: got %0b want 1", in_ready);
    end
    step("bp_take_third");
    in_valid = 1'b0;
    repeat (3) step("bp_drain");
    bad = (got_n[0] != 3);
    for (int k = 0; k < 3 && k < got_n[0]; k++)
      if (got_data[0][k] !== tok[k]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_order: got %0d tokens want 3 in push order", got_n[0]);
    end
  endtask

  task automatic test_sink();
    cfg_mask = '0; out_ready = 9'(~0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = DATA_WIDTH'($urandom);
      step("sink");
      checks++;
      if (out_valid !== '0 || occupancy > 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL sink: got vld=%h occ=%0d rdy=%0b want vld=0 occ<=1 rdy=1",
                 out_valid, occupancy, in_ready);
      end
    end
    in_valid = 1'b0;
    step("sink_idle");
  endtask

  task automatic load_partial();
    cfg_mask = 9'h1FF; out_ready = '0; in_valid = 1'b1;
    in_data = DATA_WIDTH'($urandom); step("load_a");
    in_data = DATA_WIDTH'($urandom); step("load_b");
    in_valid = 1'b0; out_ready = 9'h0F3;
    step("load_partial");
    out_ready = '0;
  endtask

  task automatic deliver_fresh(input string tag);
    logic [DATA_WIDTH-1:0] fresh;
    logic bad;
    clear_log();
    fresh = DATA_WIDTH'($urandom);
    in_valid = 1'b1; in_data = fresh; out_ready = '1;
    step(tag);
    in_valid = 1'b0;
    repeat (2) step(tag);
    bad = 1'b0;
    for (int i = 0; i < NUM_OUT; i++)
      if (got_n[i] != 1 || got_data[i][0] !== fresh) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got dest0 count=%0d data=%h want count=1 data=%h",
               tag, got_n[0], got_data[0][0], fresh);
    end
  endtask

  task automatic test_flush();
    load_partial();
    flush = 1'b1; in_valid = 1'b1; in_data = DATA_WIDTH'($urandom); out_ready = '1;
    step("flush_cycle");
    flush = 1'b0; in_valid = 1'b0; out_ready = '0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== '0) begin
      errors++;
      $display("FAIL flush_clear: got occ=%0d vld=%h want occ=0 vld=0", occupancy, out_valid);
    end
    deliver_fresh("flush_fresh");

    load_partial();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got occ=%0d vld=%h rdy=%0b want occ=0 vld=0 rdy=1",
               occupancy, out_valid, in_ready);
    end
    model_q.delete();
    accepted = '0;
    step("reset_mid");
    reset = 1'b0;
    deliver_fresh("reset_fresh");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (model_q.size() == 0 && $urandom_range(0, 7) == 0)
        cfg_mask = NUM_OUT'($urandom);
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DATA_WIDTH'($urandom);
      out_ready = NUM_OUT'($urandom) | NUM_OUT'($urandom);
      step("random");
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = '1;
    repeat (4) step("random_drain");
  endtask

  initial begin
    accepted = '0;
    clear_log();
    test_reset();
    test_stream();
    test_partial_fork();
    test_backpressure();
    test_sink();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
